// File: rtl/i2c_reg_seq.sv
// I2C register-access sequencer: pointer byte, then register writes or reads with bus ack/timeout.
// Optional macro I2C_REG_SEQ_AUTOINC_EN makes the register pointer advance after each access.
module i2c_reg_seq #(
  parameter int ADDR_W      = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i2c_start,
  input  logic              i2c_read,
  input  logic              i2c_stop,
  input  logic [7:0]        write_data,
  input  logic              write_valid,
  output logic              write_ready,
  output logic [7:0]        read_data,
  output logic              read_valid,
  input  logic              read_ready,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  input  logic              reg_ack,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, PTR, WR_WAIT, WR_BUS, RD_BUS, RD_HOLD} state_e;

  localparam logic [15:0] TMO = 16'(ACK_TIMEOUT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_inc;
  logic [15:0]       cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              rvalid_q, rvalid_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              we_q, we_d, re_q, re_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              pend_start_q, pend_start_d;
  logic              pend_stop_q, pend_stop_d;
  logic              pend_read_q, pend_read_d;

  logic ack_ok, timeout, done, eff_start, eff_stop, go_start, go_rd;

`ifdef I2C_REG_SEQ_AUTOINC_EN
  assign ptr_inc = ptr_q + ADDR_W'(1);
`else
  assign ptr_inc = ptr_q;
`endif

  // The strobe cycle itself (cnt 0) never completes a bus cycle; the earliest ack is one cycle later.
  assign ack_ok  = reg_ack && (cnt_q != 16'd0);
  assign timeout = !ack_ok && (cnt_q == TMO);
  assign done    = ack_ok || timeout;

  // A start in the completing cycle beats everything; a later stop cancels an earlier latched start.
  assign eff_start = i2c_start || (pend_start_q && !i2c_stop);
  assign eff_stop  = !i2c_start && (i2c_stop || pend_stop_q);

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = 16'd0;
    err_d        = err_q;
    rvalid_d     = rvalid_q;
    rdata_d      = rdata_q;
    we_d         = 1'b0;
    re_d         = 1'b0;
    wdata_d      = wdata_q;
    pend_start_d = pend_start_q;
    pend_stop_d  = pend_stop_q;
    pend_read_d  = pend_read_q;
    write_ready  = 1'b0;
    go_start     = 1'b0;
    go_rd        = i2c_read;

    if (state_q == WR_BUS || state_q == RD_BUS) begin
      cnt_d = cnt_q + 16'd1;
      if (i2c_start) begin
        pend_start_d = 1'b1;
        pend_stop_d  = 1'b0;
        pend_read_d  = i2c_read;
      end else if (i2c_stop) begin
        pend_stop_d  = 1'b1;
        pend_start_d = 1'b0;
      end
      if (done) begin
        cnt_d        = 16'd0;
        pend_start_d = 1'b0;
        pend_stop_d  = 1'b0;
        go_rd        = i2c_start ? i2c_read : pend_read_q;
        if (timeout) err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: if (i2c_start) go_start = 1'b1;
      PTR: begin
        write_ready = 1'b1;
        if (i2c_start) go_start = 1'b1;
        else if (i2c_stop) state_d = IDLE;
        else if (write_valid) begin
          ptr_d   = ADDR_W'(write_data);
          state_d = WR_WAIT;
        end
      end
      WR_WAIT: begin
        write_ready = 1'b1;
        if (i2c_start) go_start = 1'b1;
        else if (i2c_stop) state_d = IDLE;
        else if (write_valid) begin
          wdata_d = write_data;
          we_d    = 1'b1;
          state_d = WR_BUS;
        end
      end
      WR_BUS: if (done) begin
        ptr_d = ptr_inc;
        if (eff_start) go_start = 1'b1;
        else if (eff_stop) state_d = IDLE;
        else state_d = WR_WAIT;
      end
      RD_BUS: if (done) begin
        if (eff_start) go_start = 1'b1;
        else if (eff_stop) state_d = IDLE;
        else begin
          rdata_d  = ack_ok ? reg_rdata : 8'hFF;
          rvalid_d = 1'b1;
          state_d  = RD_HOLD;
        end
      end
      RD_HOLD: begin
        if (i2c_start) go_start = 1'b1;
        else if (i2c_stop) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end else if (read_ready) begin
          rvalid_d = 1'b0;
          ptr_d    = ptr_inc;
          re_d     = 1'b1;
          state_d  = RD_BUS;
        end
      end
      default: state_d = IDLE;
    endcase

    if (go_start) begin
      rvalid_d = 1'b0;
      re_d     = go_rd;
      state_d  = go_rd ? RD_BUS : PTR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cnt_q        <= 16'd0;
      err_q        <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= 8'h00;
      we_q         <= 1'b0;
      re_q         <= 1'b0;
      wdata_q      <= 8'h00;
      pend_start_q <= 1'b0;
      pend_stop_q  <= 1'b0;
      pend_read_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      we_q         <= we_d;
      re_q         <= re_d;
      wdata_q      <= wdata_d;
      pend_start_q <= pend_start_d;
      pend_stop_q  <= pend_stop_d;
      pend_read_q  <= pend_read_d;
    end
  end

  assign reg_addr   = ptr_q;
  assign reg_wdata  = wdata_q;
  assign reg_we     = we_q;
  assign reg_re     = re_q;
  assign read_data  = rdata_q;
  assign read_valid = rvalid_q;
  assign err        = err_q;

endmodule
